// File: rtl/wb_stage_param_pkg.sv
// Shared core constants and result-source encodings for the writeback path.
package rv_pkg;
  localparam int XLEN  = 32;
  localparam int RBITS = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } res_src_e;
endpackage

// File: rtl/wb_stage_param_if.sv
// Memory-stage to writeback bundle; WB_BYPASS_EN adds the decode bypass signals.
interface wb_stage_param_if #(
  parameter int XLEN  = 32,
  parameter int RBITS = 5,
  parameter int NSRC  = 3,
  parameter int CNT_W = 64
);
  localparam int SRC_W = $clog2(NSRC);

  logic                 stall;
  logic                 flush;
  logic                 valid_m;
  logic                 reg_write_m;
  logic [RBITS-1:0]     rd_m;
  logic [SRC_W-1:0]     result_src_m;
  logic [NSRC*XLEN-1:0] src_bus_m;
  logic                 valid_w;
  logic                 reg_write_w;
  logic [RBITS-1:0]     rd_w;
  logic [XLEN-1:0]      result_w;
  logic [CNT_W-1:0]     instret;
`ifdef WB_BYPASS_EN
  logic [RBITS-1:0]     rs1_d;
  logic [RBITS-1:0]     rs2_d;
  logic [XLEN-1:0]      rf_rd1;
  logic [XLEN-1:0]      rf_rd2;
  logic [XLEN-1:0]      rd1_d;
  logic [XLEN-1:0]      rd2_d;

  modport master (
    output stall, flush, valid_m, reg_write_m, rd_m, result_src_m, src_bus_m,
    output rs1_d, rs2_d, rf_rd1, rf_rd2,
    input  valid_w, reg_write_w, rd_w, result_w, instret, rd1_d, rd2_d
  );
  modport slave (
    input  stall, flush, valid_m, reg_write_m, rd_m, result_src_m, src_bus_m,
    input  rs1_d, rs2_d, rf_rd1, rf_rd2,
    output valid_w, reg_write_w, rd_w, result_w, instret, rd1_d, rd2_d
  );
`else
  modport master (
    output stall, flush, valid_m, reg_write_m, rd_m, result_src_m, src_bus_m,
    input  valid_w, reg_write_w, rd_w, result_w, instret
  );
  modport slave (
    input  stall, flush, valid_m, reg_write_m, rd_m, result_src_m, src_bus_m,
    output valid_w, reg_write_w, rd_w, result_w, instret
  );
`endif
endinterface

// File: rtl/wb_stage_param_result_mux.sv
// NSRC-way result mux; a select beyond the last source yields zero.
module result_mux_n #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int NSRC  = 3,
  parameter int SRC_W = $clog2(NSRC)
) (
  input  logic [NSRC*XLEN-1:0] i_bus,
  input  logic [SRC_W-1:0]     i_sel,
  output logic [XLEN-1:0]      o_y
);
  import rv_pkg::*;

  always_comb begin
    o_y = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (i_sel == SRC_W'(i)) o_y = i_bus[i*XLEN +: XLEN];
    end
  end
endmodule

// File: rtl/wb_stage_param.sv
// Writeback stage: muxes then registers the result, with stall/flush, x0 guard and instret.
// Optional WB_BYPASS_EN: combinational writeback-to-decode bypass.
module wb_stage_param #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int RBITS = rv_pkg::RBITS,
  parameter int NSRC  = 3,
  parameter int SRC_W = $clog2(NSRC),
  parameter int CNT_W = 64
) (
  input logic             clk,
  input logic             reset,
  wb_stage_param_if.slave bus
);
  import rv_pkg::*;

  logic [XLEN-1:0]  w_sel;
  logic             r_valid;
  logic             r_regw;
  logic [RBITS-1:0] r_rd;
  logic [XLEN-1:0]  r_res;
  logic [CNT_W-1:0] r_cnt;

  result_mux_n #(.XLEN(XLEN), .NSRC(NSRC), .SRC_W(SRC_W)) u_mux (
    .i_bus (bus.src_bus_m),
    .i_sel (bus.result_src_m),
    .o_y   (w_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_regw  <= 1'b0;
      r_rd    <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
    end else begin
      // The occupant leaves on any non-stalled edge, including a flush.
      if (r_valid && (!bus.stall || bus.flush)) r_cnt <= r_cnt + CNT_W'(1);
      if (bus.flush) begin
        r_valid <= 1'b0;
        r_regw  <= 1'b0;
        r_rd    <= '0;
        r_res   <= '0;
      end else if (!bus.stall) begin
        r_valid <= bus.valid_m;
        r_regw  <= bus.valid_m && bus.reg_write_m && (bus.rd_m != '0);
        r_rd    <= bus.rd_m;
        r_res   <= w_sel;
      end
    end
  end

  assign bus.valid_w     = r_valid;
  assign bus.reg_write_w = r_regw;
  assign bus.rd_w        = r_rd;
  assign bus.result_w    = r_res;
  assign bus.instret     = r_cnt;

`ifdef WB_BYPASS_EN
  assign bus.rd1_d = (r_regw && (r_rd == bus.rs1_d)) ? r_res : bus.rf_rd1;
  assign bus.rd2_d = (r_regw && (r_rd == bus.rs2_d)) ? r_res : bus.rf_rd2;
`endif
endmodule

// File: tb/tb_wb_stage_param.sv
// Scoreboard bench for wb_stage_param: spec-level slot model feeds a queue checked by a monitor.
module tb_wb_stage_param;
  import rv_pkg::*;

  localparam int XW = 32;
  localparam int RB = 5;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_stage_param_if #(.XLEN(XW), .RBITS(RB), .NSRC(NS), .CNT_W(64)) ifa ();
  wb_stage_param_if #(.XLEN(XW), .RBITS(RB), .NSRC(NS), .CNT_W(4))  ifb ();

  wb_stage_param #(.XLEN(XW), .RBITS(RB), .NSRC(NS), .CNT_W(64)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  wb_stage_param #(.XLEN(XW), .RBITS(RB), .NSRC(NS), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  typedef struct {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [63:0] cnt;
    logic [31:0] b1;
    logic [31:0] b2;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_tot  = 0;

  // Reference writeback slot and retirement count.
  logic        m_v   = 1'b0;
  logic        m_rw  = 1'b0;
  logic [4:0]  m_rd  = '0;
  logic [31:0] m_res = '0;
  longint unsigned m_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive_if(input logic st, fl, v, rw, input logic [4:0] rd,
                          input logic [1:0] src, input logic [95:0] bus);
    ifa.stall = st; ifa.flush = fl; ifa.valid_m = v; ifa.reg_write_m = rw;
    ifa.rd_m = rd; ifa.result_src_m = src; ifa.src_bus_m = bus;
    ifb.stall = st; ifb.flush = fl; ifb.valid_m = v; ifb.reg_write_m = rw;
    ifb.rd_m = rd; ifb.result_src_m = src; ifb.src_bus_m = bus;
  endtask

  task automatic step(input logic rst, st, fl, v, rw, input logic [4:0] rd,
                      input logic [1:0] src, input logic [31:0] w0, w1, w2);
    logic [31:0] words[3];
    logic [31:0] sel;
    exp_t e;
    logic [4:0]  rs1, rs2;
    logic [31:0] rf1, rf2;
    @(negedge clk);
    words[0] = w0; words[1] = w1; words[2] = w2;
    sel = (int'(src) < NS) ? words[src] : 32'd0;
    reset = rst;
    drive_if(st, fl, v, rw, rd, src, {w2, w1, w0});
    if (rst) begin
      m_v = 0; m_rw = 0; m_rd = 0; m_res = 0; m_cnt = 0;
    end else begin
      if (m_v && (!st || fl)) m_cnt++;
      if (fl) begin
        m_v = 0; m_rw = 0; m_rd = 0; m_res = 0;
      end else if (!st) begin
        m_v = v; m_rd = rd; m_res = sel; m_rw = v && rw && (rd != 0);
      end
    end
    rs1 = ($urandom % 2 == 0) ? m_rd : 5'($urandom);
    rs2 = ($urandom % 2 == 0) ? m_rd : 5'($urandom);
    rf1 = $urandom; rf2 = $urandom;
`ifdef WB_BYPASS_EN
    ifa.rs1_d = rs1; ifa.rs2_d = rs2; ifa.rf_rd1 = rf1; ifa.rf_rd2 = rf2;
    ifb.rs1_d = rs1; ifb.rs2_d = rs2; ifb.rf_rd1 = rf1; ifb.rf_rd2 = rf2;
`endif
    e.v = m_v; e.rw = m_rw; e.rd = m_rd; e.res = m_res; e.cnt = m_cnt;
    e.b1 = (m_rw && m_rd == rs1) ? m_res : rf1;
    e.b2 = (m_rw && m_rd == rs2) ? m_res : rf2;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid_w",     ifa.valid_w,     e.v);
        chk("reg_write_w", ifa.reg_write_w, e.rw);
        chk("rd_w",        ifa.rd_w,        e.rd);
        chk("result_w",    ifa.result_w,    e.res);
        chk("instret",     ifa.instret,     e.cnt);
        chk("instret4",    ifb.instret,     e.cnt % 16);
`ifdef WB_BYPASS_EN
        chk("rd1_d", ifa.rd1_d, e.b1);
        chk("rd2_d", ifa.rd2_d, e.b2);
`endif
      end
    end
  end

  initial begin
    drive_if(0, 0, 0, 0, 0, 0, 96'd0);
`ifdef WB_BYPASS_EN
    ifa.rs1_d = 0; ifa.rs2_d = 0; ifa.rf_rd1 = 0; ifa.rf_rd2 = 0;
    ifb.rs1_d = 0; ifb.rs2_d = 0; ifb.rf_rd1 = 0; ifb.rf_rd2 = 0;
`endif
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // capture, then x0 suppression
    step(0, 0, 0, 1, 1, 5, RES_MEM, 32'h1, 32'hDEADBEEF, 32'h3);
    step(0, 0, 0, 1, 1, 0, RES_ALU, 32'h12345678, 32'h2, 32'h3);
    // stall hold
    step(0, 0, 0, 1, 1, 7, RES_PC4, 32'h1, 32'h2, 32'h104);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 1, 1, 5'($urandom), 2'($urandom), $urandom, $urandom, $urandom);
    // flush over stall, then out-of-range select
    step(0, 1, 1, 1, 1, 9, RES_ALU, 32'hAA, 32'h2, 32'h3);
    step(0, 0, 0, 1, 1, 9, RES_ALU, 32'hAA, 32'h2, 32'h3);
    step(0, 0, 0, 1, 1, 4, 2'd3, 32'h11, 32'h22, 32'h33);
    // counter wrap on the 4-bit instance
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++)
      step(0, 0, 0, 1, 1, 5'(i + 1), 2'(i % 3), $urandom, $urandom, $urandom);
    for (int i = 0; i < 600; i++) begin
      logic [4:0] rd;
      rd = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
      step($urandom_range(0, 99) == 0, $urandom % 4 == 0, $urandom % 8 == 0,
           $urandom % 5 != 0, $urandom % 4 != 0, rd, 2'($urandom_range(0, 3)),
           $urandom, $urandom, $urandom);
    end
    @(negedge clk);
    @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
